dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_init_rom.sv | 32 +++
 rtl/dmem_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// The preload tables are used only when DMEM_PRELOAD_EN is defined.
package dmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PRELOAD_BASE = 128;

    localparam logic [31:0] KEY_W [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    localparam logic [31:0] PT_W  [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/dmem_init_rom.sv
// Sweep-index to init-word map. With DMEM_PRELOAD_EN defined it supplies the
// key, plaintext and S-box image; otherwise every word is zero.
module dmem_init_rom
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 9
) (
    input  logic [AW-1:0]     idx,
    output logic [DATA_W-1:0] word
);

`ifdef DMEM_PRELOAD_EN
    logic [31:0] i32;
    assign i32 = 32'(idx);

    always_comb begin
        word = '0;
        if (i32 < 32'd4)
            word = DATA_W'(KEY_W[idx[1:0]]);
        else if (i32 < 32'd8)
            word = DATA_W'(PT_W[idx[1:0]]);
        else if (i32 >= 32'(PRELOAD_BASE) && i32 < 32'(PRELOAD_BASE + 256))
            word = DATA_W'(SBOX[8'(i32 - 32'(PRELOAD_BASE))]);
    end
`else
    logic unused_idx;
    assign unused_idx = ^idx;
    assign word       = '0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with a power-up init sweep, byte-enable writes and a fixed-latency
// response pipeline. Sweep contents come from dmem_init_rom (DMEM_PRELOAD_EN).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | sweep writes init word to index cnt; requests not accepted
//   ST_RUN  | normal operation, one request accepted per cycle
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NB  = DATA_W / 8;
    localparam int AW  = $clog2(DEPTH);
    localparam int OFF = $clog2(NB);

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [DATA_W-1:0]   init_word;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [31:0]         word_addr;
    logic [AW-1:0]       idx;
    logic                in_range;
    logic                accept;

    logic [NB-1:0]       wr_be;
    logic [AW-1:0]       wr_idx;
    logic [DATA_W-1:0]   wr_data;

    logic                v_q [RD_LAT];
    logic                e_q [RD_LAT];
    logic [DATA_W-1:0]   d_q [RD_LAT];

    dmem_init_rom #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_init_rom (
        .idx  (cnt),
        .word (init_word)
    );

    assign word_addr = req_addr >> OFF;
    assign in_range  = word_addr < 32'(DEPTH);
    assign idx       = word_addr[AW-1:0];
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_RUN: ;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Single write port shared by the sweep and accepted writes.
    always_comb begin
        wr_be   = '0;
        wr_idx  = cnt;
        wr_data = init_word;
        if (state == ST_INIT) begin
            wr_be = '1;
        end else if (accept && req_we && in_range) begin
            wr_be   = req_be;
            wr_idx  = idx;
            wr_data = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b])
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                v_q[i] <= 1'b0;
                e_q[i] <= 1'b0;
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= accept;
            e_q[0] <= accept && !in_range;
            d_q[0] <= (accept && !req_we && in_range) ? mem[idx] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                e_q[i] <= e_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign rsp_valid = v_q[RD_LAT-1];
    assign rsp_err   = e_q[RD_LAT-1];
    assign rsp_rdata = d_q[RD_LAT-1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl; expected preload values follow DMEM_PRELOAD_EN.
module tb_dmem_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int RD_LAT = 1;

`ifdef DMEM_PRELOAD_EN
    localparam logic [31:0] EXP_W0   = 32'h2b7e1516;
    localparam logic [31:0] EXP_W128 = 32'h00000063;
`else
    localparam logic [31:0] EXP_W0   = 32'h0;
    localparam logic [31:0] EXP_W128 = 32'h0;
`endif

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [3:0]        req_be;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int errors = 0;
    int checks = 0;

    dmem_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // One request issued at a negedge; the response is sampled RD_LAT negedges after the accept edge.
    task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic v, output logic [31:0] d, output logic e);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = '0;
        repeat (RD_LAT - 1) @(negedge clk);
        v = rsp_valid;
        d = rsp_rdata;
        e = rsp_err;
    endtask

    // Releases reset at a negedge and counts rising edges until init_done; 0 means timeout.
    task automatic wait_sweep(output int cycles, output int stray_rsp);
        cycles    = 0;
        stray_rsp = 0;
        reset = 1'b1;
        for (int c = 1; c <= DEPTH + 20; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) stray_rsp++;
            if (init_done) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_data: got rdata=%h err=%b want 0/0", rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_init();
        int cycles, stray;
        wait_sweep(cycles, stray);
        checks++;
        if (cycles !== DEPTH) begin errors++; $display("FAIL init_latency: got %0d cycles want %0d (0 = timeout)", cycles, DEPTH); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL init_req_ready: got %b want 1", req_ready); end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL init_no_rsp: got %0d stray responses want 0", stray); end
    endtask

    task automatic test_preload();
        logic v, e;
        logic [31:0] d;
        do_req(1'b0, 4'h0, 32'h200, 32'h0, v, d, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== EXP_W128) begin
            errors++; $display("FAIL preload_0x200: got v=%b e=%b d=%h want 1/0/%h", v, e, d, EXP_W128);
        end
        do_req(1'b0, 4'h0, 32'h0, 32'h0, v, d, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== EXP_W0) begin
            errors++; $display("FAIL preload_0x0: got v=%b e=%b d=%h want 1/0/%h", v, e, d, EXP_W0);
        end
    endtask

    task automatic test_byte_enable();
        logic v, e;
        logic [31:0] d;
        do_req(1'b1, 4'b0101, 32'h40, 32'hAABBCCDD, v, d, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL be_write_rsp: got v=%b e=%b d=%h want 1/0/0", v, e, d);
        end
        do_req(1'b0, 4'h0, 32'h40, 32'h0, v, d, e);
        checks++;
        if (d !== 32'h00BB00DD) begin errors++; $display("FAIL be_readback: got %h want 00bb00dd", d); end
        do_req(1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF, v, d, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL be_zero_rsp: got v=%b e=%b want 1/0", v, e); end
        do_req(1'b0, 4'h0, 32'h43, 32'h0, v, d, e);
        checks++;
        if (d !== 32'h00BB00DD) begin errors++; $display("FAIL be_zero_unchanged: got %h want 00bb00dd", d); end
        do_req(1'b1, 4'b1000, 32'h41, 32'h11223344, v, d, e);
        do_req(1'b0, 4'h0, 32'h40, 32'h0, v, d, e);
        checks++;
        if (d !== 32'h11BB00DD) begin errors++; $display("FAIL be_upper_byte: got %h want 11bb00dd", d); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_addr  = 32'h10;
        req_wdata = 32'h12345678;
        for (int k = 1; k <= RD_LAT + 2; k++) begin
            @(negedge clk);
            exp_v = (k == RD_LAT) || (k == RD_LAT + 1);
            checks++;
            if (rsp_valid !== exp_v) begin errors++; $display("FAIL b2b_valid_k%0d: got %b want %b", k, rsp_valid, exp_v); end
            if (k == RD_LAT) begin
                checks++;
                if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL b2b_write_rsp: got d=%h e=%b want 0/0", rsp_rdata, rsp_err);
                end
            end
            if (k == RD_LAT + 1) begin
                checks++;
                if (rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL b2b_read_data: got d=%h e=%b want 12345678/0", rsp_rdata, rsp_err);
                end
            end
            if (k == 1) begin
                req_we    = 1'b0;
                req_be    = 4'h0;
                req_wdata = 32'h0;
            end else if (k == 2) begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_out_of_range();
        logic v, e;
        logic [31:0] d;
        do_req(1'b1, 4'hF, 32'h800, 32'hDEADBEEF, v, d, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL oor_write_rsp: got v=%b e=%b d=%h want 1/1/0", v, e, d);
        end
        do_req(1'b0, 4'h0, 32'h0, 32'h0, v, d, e);
        checks++;
        if (d !== EXP_W0 || e !== 1'b0) begin
            errors++; $display("FAIL oor_no_alias: got d=%h e=%b want %h/0", d, e, EXP_W0);
        end
        do_req(1'b0, 4'h0, 32'h8000_0010, 32'h0, v, d, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL oor_read_rsp: got v=%b e=%b d=%h want 1/1/0", v, e, d);
        end
        do_req(1'b0, 4'h0, 32'h7FC, 32'h0, v, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL last_word_in_range: got e=%b d=%h want 0/0", e, d);
        end
    endtask

    task automatic test_mid_reset();
        logic v, e;
        logic [31:0] d;
        int cycles, stray;
        do_req(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, v, d, e);
        do_req(1'b0, 4'h0, 32'h20, 32'h0, v, d, e);
        checks++;
        if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_pre_write: got %h want cafef00d", d); end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mid_rsp_dropped: got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (init_done !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags: got init_done=%b ready=%b want 0/0", init_done, req_ready);
        end
        repeat (3) @(negedge clk);
        wait_sweep(cycles, stray);
        checks++;
        if (cycles !== DEPTH) begin errors++; $display("FAIL mid_resweep_latency: got %0d want %0d", cycles, DEPTH); end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d stray responses want 0", stray); end
        do_req(1'b0, 4'h0, 32'h20, 32'h0, v, d, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_overwrite_0x20: got %h want 0", d); end
        do_req(1'b0, 4'h0, 32'h40, 32'h0, v, d, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_overwrite_0x40: got %h want 0", d); end
        do_req(1'b0, 4'h0, 32'h0, 32'h0, v, d, e);
        checks++;
        if (d !== EXP_W0) begin errors++; $display("FAIL mid_word0: got %h want %h", d, EXP_W0); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_preload();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
